// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: multi-read, dual-write register file with per-register
// pending (busy) scoreboard for the decode/writeback stages.
//
// Ports
//   clk          clock, all state updates on posedge
//   reset        synchronous active-low reset
//   rd_addr      NUM_RD packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd_data      NUM_RD packed read data (combinational, write-bypassed)
//   rd_busy      per read port: register pending and not written this cycle
//   wr0_*        primary write port (ALU writeback), wins on address clash
//   wr1_*        secondary write port (load/late writeback)
//   issue_en/issue_addr  mark destination register pending
//   flush        clear every busy bit
//   busy_vec     registered busy bits
//   pending_cnt  registered population count of busy_vec
//   wr_conflict  registered pulse: both ports wrote the same register last cycle
module regfile_mp_sb #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic                       wr0_en,
  input  logic [ADDR_W-1:0]          wr0_addr,
  input  logic [DATA_W-1:0]          wr0_data,
  input  logic                       wr1_en,
  input  logic [ADDR_W-1:0]          wr1_addr,
  input  logic [DATA_W-1:0]          wr1_data,
  input  logic                       issue_en,
  input  logic [ADDR_W-1:0]          issue_addr,
  input  logic                       flush,
  output logic [(1<<ADDR_W)-1:0]     busy_vec,
  output logic [ADDR_W:0]            pending_cnt,
  output logic                       wr_conflict
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam bit          HAS_Z = (ZERO_REG != 0);

  // Storage and scoreboard state
  logic [DEPTH-1:0][DATA_W-1:0] r_mem;
  logic [DEPTH-1:0]             r_busy;
  logic [CNT_W-1:0]             r_cnt;
  logic                         r_conflict;

  logic             w_wr0_eff;
  logic             w_wr1_eff;
  logic             w_issue_eff;
  logic             w_conflict;
  logic [DEPTH-1:0] w_busy_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;

  // Effective write/issue qualifiers; register 0 is excluded when hardwired
  assign w_wr0_eff   = wr0_en   && !(HAS_Z && (wr0_addr   == '0));
  assign w_wr1_eff   = wr1_en   && !(HAS_Z && (wr1_addr   == '0));
  assign w_issue_eff = issue_en && !(HAS_Z && (issue_addr == '0));
  assign w_conflict  = w_wr0_eff && w_wr1_eff && (wr0_addr == wr1_addr);

  // Scoreboard next state: write clears, issue (newer producer) sets, flush clears all
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_wr0_eff)   w_busy_nxt[wr0_addr]   = 1'b0;
    if (w_wr1_eff)   w_busy_nxt[wr1_addr]   = 1'b0;
    if (w_issue_eff) w_busy_nxt[issue_addr] = 1'b1;
    if (flush)       w_busy_nxt             = '0;
  end

  // Population count of the next busy vector so pending_cnt tracks busy_vec exactly
  always_comb begin
    w_cnt_nxt = '0;
    for (int unsigned a = 0; a < DEPTH; a++) begin
      w_cnt_nxt = w_cnt_nxt + CNT_W'(w_busy_nxt[a]);
    end
  end

  // State update; wr0 is applied last so it wins a same-address clash
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_mem      <= '0;
      r_busy     <= '0;
      r_cnt      <= '0;
      r_conflict <= 1'b0;
    end else begin
      if (w_wr1_eff) r_mem[wr1_addr] <= wr1_data;
      if (w_wr0_eff) r_mem[wr0_addr] <= wr0_data;
      r_busy     <= w_busy_nxt;
      r_cnt      <= w_cnt_nxt;
      r_conflict <= w_conflict;
    end
  end

  assign busy_vec    = r_busy;
  assign pending_cnt = r_cnt;
  assign wr_conflict = r_conflict;

  // Per-port combinational read with same-cycle write bypass
  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    logic              w_hit0;
    logic              w_hit1;
    logic              w_zero;
    logic [DATA_W-1:0] w_rdata;

    assign w_ra   = rd_addr[g*ADDR_W +: ADDR_W];
    assign w_hit0 = w_wr0_eff && (wr0_addr == w_ra);
    assign w_hit1 = w_wr1_eff && (wr1_addr == w_ra);
    assign w_zero = HAS_Z && (w_ra == '0);

    always_comb begin
      w_rdata = r_mem[w_ra];
      if (w_hit1)           w_rdata = wr1_data;
      if (w_hit0)           w_rdata = wr0_data;
      if (w_zero || !reset) w_rdata = '0;
    end

    assign rd_data[g*DATA_W +: DATA_W] = w_rdata;
    // A write landing this cycle satisfies the pending read
    assign rd_busy[g] = reset && !w_zero && r_busy[w_ra] && !w_hit0 && !w_hit1;
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Self-checking bench for regfile_mp_sb (4 read ports, 32x32, zero register).
module tb_regfile_mp_sb;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 4;
  localparam int NREG = 32;

  logic              clk;
  logic              reset;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*DW-1:0]  rd_data;
  logic [NR-1:0]     rd_busy;
  logic              wr0_en, wr1_en, issue_en, flush;
  logic [AW-1:0]     wr0_addr, wr1_addr, issue_addr;
  logic [DW-1:0]     wr0_data, wr1_data;
  logic [NREG-1:0]   busy_vec;
  logic [AW:0]       pending_cnt;
  logic              wr_conflict;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [DW-1:0]   m_mem [NREG];
  logic [NREG-1:0] m_busy;
  logic            m_conf;

  regfile_mp_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .issue_en(issue_en), .issue_addr(issue_addr), .flush(flush),
    .busy_vec(busy_vec), .pending_cnt(pending_cnt), .wr_conflict(wr_conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] port_data(input int k);
    return rd_data[k*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    if (!reset || a == 0)                return '0;
    if (wr0_en && wr0_addr == a)         return wr0_data;
    if (wr1_en && wr1_addr == a)         return wr1_data;
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    return reset && (a != 0) && m_busy[a] &&
           !(wr0_en && wr0_addr == a) && !(wr1_en && wr1_addr == a);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) m_mem[i] = '0;
    m_busy = '0;
    m_conf = 1'b0;
  endtask

  task automatic model_step();
    logic w0, w1;
    if (!reset) begin
      model_reset();
    end else begin
      w0 = wr0_en && wr0_addr != 0;
      w1 = wr1_en && wr1_addr != 0;
      if (w1) m_mem[wr1_addr] = wr1_data;
      if (w0) m_mem[wr0_addr] = wr0_data;
      m_conf = w0 && w1 && (wr0_addr == wr1_addr);
      if (flush) m_busy = '0;
      else begin
        if (w0) m_busy[wr0_addr] = 1'b0;
        if (w1) m_busy[wr1_addr] = 1'b0;
        if (issue_en && issue_addr != 0) m_busy[issue_addr] = 1'b1;
      end
    end
  endtask

  // Check all outputs against the model at negedge, then advance one clock
  task automatic cycle();
    logic [AW-1:0] a;
    @(negedge clk);
    for (int k = 0; k < NR; k++) begin
      a = rd_addr[k*AW +: AW];
      chk($sformatf("rd_data%0d", k), 64'(port_data(k)), 64'(exp_rd(a)));
      chk($sformatf("rd_busy%0d", k), 64'(rd_busy[k]), 64'(exp_busy(a)));
    end
    chk("busy_vec", 64'(busy_vec), 64'(m_busy));
    chk("pending_cnt", 64'(pending_cnt), 64'($countones(m_busy)));
    chk("wr_conflict", 64'(wr_conflict), 64'(m_conf));
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    wr0_en = 0; wr1_en = 0; issue_en = 0; flush = 0;
  endtask

  task automatic set_rd(input int k, input int a);
    rd_addr[k*AW +: AW] = AW'(a);
  endtask

  int cnt_before;

  initial begin
    reset = 0; rd_addr = '0; idle();
    wr0_addr = '0; wr1_addr = '0; issue_addr = '0; wr0_data = '0; wr1_data = '0;
    @(posedge clk); #1;
    model_reset();

    // Reset: write and issue during reset are discarded
    wr0_en = 1; wr0_addr = 5; wr0_data = 32'hDEADBEEF;
    issue_en = 1; issue_addr = 3;
    for (int k = 0; k < NR; k++) set_rd(k, 5);
    #2;
    chk("rst_rd_data", 64'(port_data(0)), 64'h0);
    chk("rst_rd_busy", 64'(rd_busy), 64'h0);
    cycle();
    reset = 1; idle();
    #2;
    chk("rst_busy_vec", 64'(busy_vec), 64'h0);
    chk("rst_pending", 64'(pending_cnt), 64'h0);
    for (int a = 0; a < NREG; a++) begin
      for (int k = 0; k < NR; k++) set_rd(k, (a + k) % NREG);
      #2;
      chk("sweep_rd0", 64'(port_data(0)), 64'h0);
      chk("sweep_rd1", 64'(port_data(1)), 64'h0);
      cycle();
    end

    // Dual write to the same register: wr0 wins, conflict pulses once
    wr0_en = 1; wr0_addr = 3; wr0_data = 32'h11;
    wr1_en = 1; wr1_addr = 3; wr1_data = 32'h22;
    set_rd(0, 3);
    #2; chk("clash_bypass", 64'(port_data(0)), 64'h11);
    cycle();
    idle(); #2;
    chk("clash_stored", 64'(port_data(0)), 64'h11);
    chk("conflict_pulse", 64'(wr_conflict), 64'h1);
    cycle();
    #2; chk("conflict_clear", 64'(wr_conflict), 64'h0);
    cycle();

    // Issue then satisfy by wr1 with bypass
    issue_en = 1; issue_addr = 7; cycle();
    idle(); set_rd(1, 7); #2;
    chk("issue_busy", 64'(rd_busy[1]), 64'h1);
    chk("issue_cnt", 64'(pending_cnt), 64'h1);
    cycle();
    wr1_en = 1; wr1_addr = 7; wr1_data = 32'hABCD; #2;
    chk("wb_busy_clr", 64'(rd_busy[1]), 64'h0);
    chk("wb_bypass", 64'(port_data(1)), 64'hABCD);
    cycle();
    idle(); #2; chk("wb_cnt", 64'(pending_cnt), 64'h0);
    cycle();

    // Same-cycle issue and write: data stored, busy set
    issue_en = 1; issue_addr = 9; wr0_en = 1; wr0_addr = 9; wr0_data = 32'h55;
    cycle();
    idle(); set_rd(0, 9); #2;
    chk("iw_data", 64'(port_data(0)), 64'h55);
    chk("iw_busy", 64'(busy_vec[9]), 64'h1);
    cycle();

    // Flush overrides a same-cycle issue
    issue_en = 1; issue_addr = 1; cycle();
    issue_addr = 2; cycle();
    issue_addr = 4; cycle();
    idle(); #2; chk("pre_flush_cnt", 64'(pending_cnt), 64'h4);
    flush = 1; issue_en = 1; issue_addr = 6; cycle();
    idle(); #2;
    chk("flush_vec", 64'(busy_vec), 64'h0);
    chk("flush_cnt", 64'(pending_cnt), 64'h0);
    cycle();

    // Register 0 is hardwired: never written, never busy, on every port
    issue_en = 1; issue_addr = 12; cycle();
    idle(); cnt_before = int'(pending_cnt);
    wr0_en = 1; wr0_addr = 0; wr0_data = 32'hFFFF; issue_en = 1; issue_addr = 0;
    for (int k = 0; k < NR; k++) set_rd(k, 0);
    #2;
    for (int k = 0; k < NR; k++) chk($sformatf("zero_bypass%0d", k), 64'(port_data(k)), 64'h0);
    cycle();
    idle(); #2;
    for (int k = 0; k < NR; k++) begin
      chk($sformatf("zero_data%0d", k), 64'(port_data(k)), 64'h0);
      chk($sformatf("zero_busy%0d", k), 64'(rd_busy[k]), 64'h0);
    end
    chk("zero_vec0", 64'(busy_vec[0]), 64'h0);
    chk("zero_cnt", 64'(pending_cnt), 64'(cnt_before));
    cycle();

    // Randomized traffic against the model, with occasional mid-run reset
    for (int n = 0; n < 3000; n++) begin
      reset      = ($urandom_range(0, 63) != 0);
      flush      = ($urandom_range(0, 15) == 0);
      issue_en   = $urandom_range(0, 1) == 1;
      wr0_en     = $urandom_range(0, 1) == 1;
      wr1_en     = $urandom_range(0, 1) == 1;
      issue_addr = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      wr0_addr   = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      wr1_addr   = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      wr0_data   = $urandom;
      wr1_data   = $urandom;
      for (int k = 0; k < NR; k++)
        set_rd(k, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7)));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
